// File: rtl/uart_frame_scheduler.sv
// Round-robin scheduler that shares one byte-wide UART transmitter between three
// 32-bit sources, sending each granted word as an 8-byte "P<tag><4 bytes>\r\n" frame.
module uart_frame_scheduler #(
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        tx_idle,
  output logic [2:0]  ack,
  output logic [7:0]  dataout,
  output logic        wrsig,
  output logic        busy,
  output logic [1:0]  cur_chan
);

  typedef enum logic [1:0] {IDLE, SEND, GUARD} state_t;

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  guard_q, guard_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] frame_q, frame_d;
  logic [7:0]  dataout_d;
  logic        wrsig_d;
  logic [2:0]  ack_d;
  logic        busy_d;
  logic [1:0]  cur_chan_d;

  logic        grant_valid;
  logic [1:0]  grant_ch;
  logic [1:0]  cand1, cand2;

  function automatic logic [1:0] inc_mod3(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [1:0] chan,
                                            input logic [31:0] word);
    case (idx)
      3'd0:    return 8'h50;
      3'd1:    return 8'h31 + {6'b0, chan};
      3'd2:    return word[31:24];
      3'd3:    return word[23:16];
      3'd4:    return word[15:8];
      3'd5:    return word[7:0];
      3'd6:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Search order last+1, last+2, last+3 (== last) keeps a steady requester
  // from starving the others while still allowing back-to-back grants.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    grant_valid = 1'b0;
    grant_ch    = 2'd0;
    cand1       = inc_mod3(last_q);
    cand2       = inc_mod3(cand1);
    if (req[cand1]) begin
      grant_valid = 1'b1;
      grant_ch    = cand1;
    end else if (req[cand2]) begin
      grant_valid = 1'b1;
      grant_ch    = cand2;
    end else if (req[last_q]) begin
      grant_valid = 1'b1;
      grant_ch    = last_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    guard_d    = guard_q;
    last_d     = last_q;
    frame_d    = frame_q;
    dataout_d  = dataout;
    wrsig_d    = 1'b0;
    ack_d      = 3'b000;
    busy_d     = busy;
    cur_chan_d = cur_chan;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          case (grant_ch)
            2'd0:    frame_d = data0;
            2'd1:    frame_d = data1;
            default: frame_d = data2;
          endcase
          ack_d      = 3'(3'b001 << grant_ch);
          last_d     = grant_ch;
          cur_chan_d = grant_ch;
          busy_d     = 1'b1;
          idx_d      = 3'd0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_idle) begin
          dataout_d = frame_byte(idx_q, cur_chan, frame_q);
          wrsig_d   = 1'b1;
          guard_d   = GUARD_LOAD;
          state_d   = GUARD;
        end
      end
      GUARD: begin
        // tx_idle is deliberately ignored here: the transmitter may not yet
        // have raised busy in response to the strobe just issued.
        if (guard_q == 4'd0) begin
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SEND;
          end
        end else begin
          guard_d = guard_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      guard_q  <= 4'd0;
      last_q   <= 2'd2;
      frame_q  <= 32'd0;
      dataout  <= 8'd0;
      wrsig    <= 1'b0;
      ack      <= 3'b000;
      busy     <= 1'b0;
      cur_chan <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      guard_q  <= guard_d;
      last_q   <= last_d;
      frame_q  <= frame_d;
      dataout  <= dataout_d;
      wrsig    <= wrsig_d;
      ack      <= ack_d;
      busy     <= busy_d;
      cur_chan <= cur_chan_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed self-checking bench for uart_frame_scheduler: single frame, contention,
// late request, data stability, back-pressure and asynchronous reset mid-frame.
module tb_uart_frame_scheduler;

  localparam int GC = 4;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [31:0] data0, data1, data2;
  logic        tx_idle;
  logic [2:0]  ack;
  logic [7:0]  dataout;
  logic        wrsig;
  logic        busy;
  logic [1:0]  cur_chan;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int stray    = 0;

  uart_frame_scheduler #(.GUARD_CYCLES(GC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .tx_idle  (tx_idle),
    .ack      (ack),
    .dataout  (dataout),
    .wrsig    (wrsig),
    .busy     (busy),
    .cur_chan (cur_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [1:0] ch, input logic [31:0] w, input int i);
    case (i)
      0:       return 8'h50;
      1:       return 8'h31 + {6'b0, ch};
      2:       return w[31:24];
      3:       return w[23:16];
      4:       return w[15:8];
      5:       return w[7:0];
      6:       return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  task automatic set_data(input logic [1:0] ch, input logic [31:0] v);
    case (ch)
      2'd0:    data0 = v;
      2'd1:    data1 = v;
      default: data2 = v;
    endcase
  endtask

  task automatic wait_ack(output int at);
    bit ok = 1'b0;
    at = cyc;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (ack !== 3'b000) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    check("ack_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_wrsig(output logic [7:0] b, output int at);
    bit ok = 1'b0;
    b  = 8'h00;
    at = cyc;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (ack !== 3'b000) stray++;
      if (wrsig === 1'b1) begin
        ok = 1'b1;
        b  = dataout;
        at = cyc;
      end
    end
    check("wrsig_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_busy_low(output int at);
    bit ok = 1'b0;
    at = cyc;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (ack !== 3'b000) stray++;
      if (busy === 1'b0) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    check("busy_fall_seen", 32'(ok), 32'd1);
  endtask

  // One full frame with tx_idle held high. drop clears req bits after ack,
  // inj sets req bits after byte 3, clr zeroes the channel's word after byte 0.
  task automatic run_frame(input logic [1:0] ch, input logic [31:0] word, input logic [2:0] drop,
                           input logic [2:0] inj, input bit clr,
                           output int ack_cyc, output int end_cyc);
    logic [7:0] b;
    int at, prev;
    wait_ack(ack_cyc);
    check("ack_onehot", 32'(ack), 32'(3'(3'b001 << ch)));
    check("cur_chan", 32'(cur_chan), 32'(ch));
    check("busy_at_grant", 32'(busy), 32'd1);
    req   = req & ~drop;
    stray = 0;
    prev  = ack_cyc;
    for (int i = 0; i < 8; i++) begin
      wait_wrsig(b, at);
      check($sformatf("byte%0d_ch%0d", i, ch), 32'(b), 32'(exp_byte(ch, word, i)));
      check($sformatf("gap%0d_ch%0d", i, ch), 32'(at - prev), (i == 0) ? 32'd1 : 32'(GC + 1));
      prev = at;
      if (i == 0 && clr) set_data(ch, 32'h0);
      if (i == 3) req = req | inj;
    end
    wait_busy_low(end_cyc);
    check("busy_fall_delay", 32'(end_cyc - prev), 32'(GC));
    check("no_ack_in_frame", 32'(stray), 32'd0);
  endtask

  initial begin
    int a0, e0, a1, e1, at, set_at, viol;
    logic [7:0] b;

    rst_n   = 1'b0;
    req     = 3'b000;
    data0   = 32'h0;
    data1   = 32'h0;
    data2   = 32'h0;
    tx_idle = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_dataout", 32'(dataout), 32'h0);
    check("rst_wrsig", 32'(wrsig), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cur_chan", 32'(cur_chan), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, channel 0
    req   = 3'b001;
    data0 = 32'h12345678;
    run_frame(2'd0, 32'h12345678, 3'b001, 3'b000, 1'b0, a0, e0);

    // Late request: channel 2 raised during channel 0's frame
    req   = 3'b001;
    data0 = 32'h11223344;
    data2 = 32'h55667788;
    run_frame(2'd0, 32'h11223344, 3'b001, 3'b100, 1'b0, a0, e0);
    run_frame(2'd2, 32'h55667788, 3'b100, 3'b000, 1'b0, a1, e1);
    check("late_req_idle_gap", 32'(a1 - e0), 32'd1);

    // Contention: all three held, expect 0,1,2,0
    data0 = 32'hA0A1A2A3;
    data1 = 32'hB0B1B2B3;
    data2 = 32'hC0C1C2C3;
    req   = 3'b111;
    run_frame(2'd0, 32'hA0A1A2A3, 3'b000, 3'b000, 1'b0, a0, e0);
    run_frame(2'd1, 32'hB0B1B2B3, 3'b000, 3'b000, 1'b0, a1, e1);
    check("rr_gap_0_1", 32'(a1 - e0), 32'd1);
    run_frame(2'd2, 32'hC0C1C2C3, 3'b000, 3'b000, 1'b0, a0, e0);
    run_frame(2'd0, 32'hA0A1A2A3, 3'b111, 3'b000, 1'b0, a1, e1);

    // Data stability: data1 cleared one cycle after ack
    data1 = 32'hAABBCCDD;
    req   = 3'b010;
    run_frame(2'd1, 32'hAABBCCDD, 3'b010, 3'b000, 1'b1, a0, e0);

    // Back-pressure: tx_idle low for 20 cycles once byte 1's guard has expired
    data0 = 32'hDEADBEEF;
    req   = 3'b001;
    wait_ack(a0);
    check("bp_ack", 32'(ack), 32'h1);
    req = 3'b000;
    for (int i = 0; i < 2; i++) begin
      wait_wrsig(b, at);
      check($sformatf("bp_byte%0d", i), 32'(b), 32'(exp_byte(2'd0, 32'hDEADBEEF, i)));
    end
    tx_idle = 1'b0;
    repeat (GC) @(negedge clk);
    viol = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (wrsig !== 1'b0 || dataout !== 8'h31) viol++;
    end
    check("bp_quiet", 32'(viol), 32'd0);
    tx_idle = 1'b1;
    set_at  = cyc;
    wait_wrsig(b, at);
    check("bp_resume_delay", 32'(at - set_at), 32'd1);
    check("bp_byte2", 32'(b), 32'hDE);
    for (int i = 3; i < 8; i++) begin
      wait_wrsig(b, at);
      check($sformatf("bp_byte%0d", i), 32'(b), 32'(exp_byte(2'd0, 32'hDEADBEEF, i)));
    end
    wait_busy_low(e0);

    // Asynchronous reset in the middle of a channel 2 frame
    data2 = 32'h13579BDF;
    req   = 3'b100;
    wait_ack(a0);
    check("mr_ack", 32'(ack), 32'h4);
    req = 3'b000;
    for (int i = 0; i < 5; i++) begin
      wait_wrsig(b, at);
      check($sformatf("mr_byte%0d", i), 32'(b), 32'(exp_byte(2'd2, 32'h13579BDF, i)));
    end
    #2 rst_n = 1'b0;
    #1;
    check("mr_dataout", 32'(dataout), 32'h0);
    check("mr_busy", 32'(busy), 32'h0);
    check("mr_cur_chan", 32'(cur_chan), 32'h0);
    check("mr_wrsig", 32'(wrsig), 32'h0);
    check("mr_ack_zero", 32'(ack), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    data0 = 32'h0F1E2D3C;
    data1 = 32'h4B5A6978;
    data2 = 32'h8796A5B4;
    req   = 3'b111;
    run_frame(2'd0, 32'h0F1E2D3C, 3'b111, 3'b000, 1'b0, a0, e0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
